// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM burst stream reader.
// Contents:
//   state_e : controller state encoding (IDLE / ISSUE / DRAIN)
//   RD_LAT  : BRAM read latency in cycles (address to data)
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam int RD_LAT = 2;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Small synchronous first-word-fall-through FIFO used as the output buffer
// of the stream reader. Push and pop may happen in the same cycle.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i (ignored when full)
//   wdata_i       : write data
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry (valid while empty_o is low)
//   empty_o       : no entries stored
//   count_o       : number of stored entries
module sync_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    assign empty_o = (count_q == '0);
    assign full_s  = (count_q == CW'(DEPTH));
    assign push_s  = push_i & ~full_s;
    assign pop_s   = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since empty_o masks them.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_s) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a BRAM read port (fixed 2-cycle latency) and
// streams them out over a valid/ready interface with a last marker.
// Reads are only issued when the output FIFO is guaranteed room for the
// returning data, so the FIFO can never overflow.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : burst command handshake (ready only in IDLE)
//   cmd_addr, cmd_len       : burst start address and length (0..2^ADDR)
//   mem_addr, mem_wr        : BRAM address, write enable (always 0)
//   mem_rdata               : BRAM read data, RD_LAT cycles after address
//   out_valid/out_ready     : output stream handshake
//   out_data, out_last      : streamed word and final-word marker
//   busy                    : controller not in IDLE
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA  = 72,
    parameter int ADDR  = 10,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [ADDR:0]   cmd_len,
    output logic [ADDR-1:0] mem_addr,
    output logic            mem_wr,
    input  logic [DATA-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [ADDR:0]     rem_q, rem_d;
    logic [RD_LAT-1:0] pv_q;
    logic [RD_LAT-1:0] pl_q;

    logic              issue_s;
    logic              last_issue_s;
    logic [CW-1:0]     inflight_s;
    logic [CW-1:0]     fifo_count_s;
    logic [CW:0]       used_s;
    logic              fifo_empty_s;
    logic [DATA:0]     fifo_head_s;
    logic              pop_s;
    logic              drain_done_s;

    // Reads in flight are exactly the set valid bits of the latency pipeline.
    assign inflight_s   = CW'($countones(pv_q));
    assign used_s       = {1'b0, fifo_count_s} + {1'b0, inflight_s};
    assign pop_s        = ~fifo_empty_s & out_ready;
    // Leave DRAIN on the same edge that the last word is consumed.
    assign drain_done_s = (inflight_s == '0) &&
                          (fifo_empty_s || (pop_s && fifo_head_s[DATA]));

    // Next-state, address and remaining-count logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if ((rem_q != '0) && (used_s < DEPTH_W)) begin
                    issue_s = 1'b1;
                    addr_d  = addr_q + ADDR'(1);
                    rem_d   = rem_q - (ADDR+1)'(1);
                    if (rem_q == (ADDR+1)'(1)) begin
                        last_issue_s = 1'b1;
                        state_d      = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, address, remaining count and read-tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pv_q    <= {pv_q[RD_LAT-2:0], issue_s};
            pl_q    <= {pl_q[RD_LAT-2:0], last_issue_s};
        end
    end

    sync_fifo #(
        .WIDTH (DATA + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (pv_q[RD_LAT-1]),
        .wdata_i ({pl_q[RD_LAT-1], mem_rdata}),
        .pop_i   (pop_s),
        .rdata_o (fifo_head_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wr    = 1'b0;
    assign out_valid = ~fifo_empty_s;
    assign out_data  = fifo_head_s[DATA-1:0];
    assign out_last  = fifo_head_s[DATA] & ~fifo_empty_s;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: directed bursts against a
// behavioural 2-cycle-latency BRAM with known contents.
module tb_bram_stream_reader;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [9:0]   cmd_addr;
    logic [10:0]  cmd_len;
    logic [9:0]   mem_addr;
    logic         mem_wr;
    logic [71:0]  mem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [71:0]  out_data;
    logic         out_last;
    logic         busy;

    logic [71:0]  mem [1024];
    logic [71:0]  rd1;
    logic [71:0]  rd2;

    int           chk_cnt = 0;
    int           err_cnt = 0;

    bram_stream_reader #(.DATA(72), .ADDR(10), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data appears two rising edges after the address.
    always @(posedge clk) begin
        rd1 <= mem[mem_addr];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [9:0] a, input logic [10:0] n);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        check_eq("cmd_ready_at_accept", 72'(cmd_ready), 72'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: ready held high, 1: stalled 10 cycles then high, 2: random ready
    task automatic run_burst(input logic [9:0] start, input int len, input int mode);
        int         got;
        int         first_lat;
        int         last_lat;
        logic [9:0] a;
        got       = 0;
        first_lat = -1;
        last_lat  = -1;
        send_cmd(start, 11'(len));
        for (int i = 0; i < 20000 && got < len; i++) begin
            if (mode == 1) out_ready = (i >= 10);
            else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            if (mode == 1 && i == 10) begin
                check_eq("stall_issue_count", 72'(mem_addr - start), 72'(4));
            end
            if (out_valid) begin
                if (first_lat < 0) first_lat = i;
                if (out_ready) begin
                    a = start + 10'(got);
                    check_eq("data", out_data, mem[a]);
                    check_eq("last", 72'(out_last), 72'(got == len - 1));
                    last_lat = i;
                    got++;
                end
            end
            @(negedge clk);
        end
        check_eq("word_count", 72'(got), 72'(len));
        check_eq("idle_after_burst", 72'(busy), 72'(0));
        check_eq("ready_after_burst", 72'(cmd_ready), 72'(1));
        check_eq("no_extra_word", 72'(out_valid), 72'(0));
        if (mode == 0) begin
            check_eq("first_latency", 72'(first_lat), 72'(3));
            check_eq("last_latency", 72'(last_lat), 72'(3 + len - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {24'hC0FFEE ^ 24'(i), 24'(i * 7), 24'(i)};
        end
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 10'h000;
        cmd_len   = 11'h000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_cmd_ready", 72'(cmd_ready), 72'(1));
        check_eq("rst_busy", 72'(busy), 72'(0));
        check_eq("rst_out_valid", 72'(out_valid), 72'(0));
        check_eq("rst_out_last", 72'(out_last), 72'(0));
        check_eq("rst_mem_addr", 72'(mem_addr), 72'(0));
        check_eq("rst_mem_wr", 72'(mem_wr), 72'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic burst, then wrap across the top of the address space
        run_burst(10'h010, 4, 0);
        run_burst(10'h3FE, 4, 0);

        // Consumer stall: only DEPTH reads may be outstanding
        run_burst(10'h200, 8, 1);
        check_eq("mem_wr_low", 72'(mem_wr), 72'(0));

        // Zero-length command is accepted and ignored
        out_ready = 1'b1;
        send_cmd(10'h055, 11'h000);
        for (int i = 0; i < 4; i++) begin
            check_eq("zero_cmd_ready", 72'(cmd_ready), 72'(1));
            check_eq("zero_busy", 72'(busy), 72'(0));
            check_eq("zero_out_valid", 72'(out_valid), 72'(0));
            @(negedge clk);
        end

        // Reset during the third issue of a 16-word burst
        out_ready = 1'b0;
        send_cmd(10'h100, 11'd16);
        @(negedge clk);
        @(negedge clk);
        check_eq("third_issue_addr", 72'(mem_addr), 72'(10'h102));
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 72'(out_valid), 72'(0));
        check_eq("midrst_cmd_ready", 72'(cmd_ready), 72'(1));
        check_eq("midrst_busy", 72'(busy), 72'(0));
        check_eq("midrst_mem_addr", 72'(mem_addr), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(10'h020, 2, 0);

        // Full-memory burst with random backpressure
        run_burst(10'h000, 1024, 2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA, default 72, memory word width in bits.
REQ-002 SHALL have parameter ADDR, default 10, memory address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  a read burst command is offered.
REQ-007 SHALL have port cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_addr  input  ADDR  burst start address.
REQ-009 SHALL have port cmd_len  input  ADDR+1  burst length in words, 0 to 2^ADDR.
REQ-010 SHALL have port mem_addr  output  ADDR  read address to the dual-port BRAM port.
REQ-011 SHALL have port mem_wr  output  1  write enable to the BRAM port, constant 0.
REQ-012 SHALL have port mem_rdata  input  DATA  BRAM read data, valid exactly 2 cycles after its address.
REQ-013 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the word when out_valid is also high.
REQ-015 SHALL have port out_data  output  DATA  streamed word.
REQ-016 SHALL have port out_last  output  1  marks the final word of a burst.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-019 SHALL move IDLE->ISSUE on command acceptance with cmd_len>0, and SHALL stay in IDLE with no output on acceptance with cmd_len=0.
REQ-020 SHALL issue one read per cycle in ISSUE only when fifo_count + inflight < DEPTH (credit rule), where inflight counts issued reads whose data has not yet arrived.
REQ-021 SHALL drive the issued address on mem_addr and tag the read in a 2-stage valid/last pipeline aligned to the BRAM latency.
REQ-022 SHALL write mem_rdata into the FIFO exactly 2 cycles after the corresponding issue; overflow SHALL be impossible by REQ-020.
REQ-023 SHALL increment the address modulo 2^ADDR, so a burst crossing the top wraps to address 0.
REQ-024 SHALL move ISSUE->DRAIN after the last issue, and DRAIN->IDLE when inflight=0, the FIFO is empty and the last word has been accepted.
REQ-025 SHALL present FIFO head on out_data/out_last with out_valid=~empty (first-word-fall-through); minimum latency from command acceptance to out_valid is 3 cycles.
REQ-026 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL support simultaneous FIFO push and pop in one cycle, leaving the count unchanged.
REQ-028 SHALL sustain one word per cycle with out_ready held high.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state IDLE, counters, FIFO pointers and pipeline valids to 0; resulting outputs: cmd_ready=1, busy=0, out_valid=0, out_last=0, mem_addr=0, mem_wr=0.
REQ-030 SHALL discard any in-flight reads and buffered words when reset asserts mid-burst; out_data contents are don't-care after reset.

Structure
REQ-031 SHALL place the state enumeration and latency constant RD_LAT=2 in the shared package.
REQ-032 SHALL implement the output buffer as one sub-module, sync_fifo, parameterised by width DATA+1 and DEPTH.

Verification
REQ-033 Bench SHALL cover: cmd_addr=0x010, cmd_len=4, out_ready=1 -> words mem[0x010..0x013] on 4 consecutive cycles, first out_valid 3 cycles after accept, out_last on the 4th word.
REQ-034 Bench SHALL cover: cmd_addr=0x3FE, cmd_len=4 -> words from addresses 0x3FE, 0x3FF, 0x000, 0x001 in order.
REQ-035 Bench SHALL cover: cmd_len=8, out_ready=0 for 10 cycles then 1 -> exactly DEPTH=4 reads issued while stalled, no word lost or duplicated, 8 words total.
REQ-036 Bench SHALL cover: cmd_len=0 -> cmd_ready stays 1, busy stays 0, no out_valid.
REQ-037 Bench SHALL cover: rst_n pulsed low on the 3rd issue of a cmd_len=16 burst -> out_valid=0 and cmd_ready=1 immediately; a new cmd_len=2 burst then returns exactly 2 words.
REQ-038 Bench SHALL cover: random out_ready toggling over 1024-word burst cmd_len=1024 -> all 1024 words in address order, out_last only on the final word.
